// File: rtl/sram_1rw1r_bank.sv
// One read/write plus one read-only SRAM bank with byte-lane write mask,
// registered read pipelines and a saturating same-address collision counter.
module sram_1rw1r_bank #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  conflict,
    output logic [15:0]           conflict_count
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [READ_LATENCY-1:0] p0_valid;
    logic [READ_LATENCY-1:0] p1_valid;
    logic [DATA_WIDTH-1:0]   p0_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   p1_data [READ_LATENCY];

    logic wr0;
    logic rd0;
    logic rd1;
    logic collide;

    // Operations presented on a reset edge are dropped entirely.
    assign wr0     = rstb && !csb0 && !web0;
    assign rd0     = rstb && !csb0 && web0;
    assign rd1     = rstb && !csb1;
    assign collide = wr0 && rd1 && (|wmask0) && (addr0 == addr1);

    // Array is never reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (wr0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Array reads use the pre-edge contents, giving read-before-write on collision.
    // Data stages only load behind a valid bit, so the last stage holds between reads.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            p0_valid       <= '0;
            p1_valid       <= '0;
            conflict       <= 1'b0;
            conflict_count <= 16'd0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                p0_data[i] <= '0;
                p1_data[i] <= '0;
            end
        end else begin
            p0_valid[0] <= rd0;
            p1_valid[0] <= rd1;
            if (rd0) begin
                p0_data[0] <= mem[addr0];
            end
            if (rd1) begin
                p1_data[0] <= mem[addr1];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                p0_valid[i] <= p0_valid[i-1];
                p1_valid[i] <= p1_valid[i-1];
                if (p0_valid[i-1]) begin
                    p0_data[i] <= p0_data[i-1];
                end
                if (p1_valid[i-1]) begin
                    p1_data[i] <= p1_data[i-1];
                end
            end
            conflict <= collide;
            if (collide && (conflict_count != 16'hFFFF)) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end

    assign dout0       = p0_data[READ_LATENCY-1];
    assign dout0_valid = p0_valid[READ_LATENCY-1];
    assign dout1       = p1_data[READ_LATENCY-1];
    assign dout1_valid = p1_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1rw1r_bank.sv
// Directed bench for sram_1rw1r_bank: three instances (latency 2, 1, 4) share
// stimulus; expected reads are queued with their due cycle and checked on output.
module tb_sram_1rw1r_bank;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstb;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;

    logic [31:0] d0_w [3];
    logic [31:0] d1_w [3];
    logic        v0_w [3];
    logic        v1_w [3];
    logic        cf_w [3];
    logic [15:0] cc_w [3];

    exp_t q0 [3][$];
    exp_t q1 [3][$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_1rw1r_bank #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (8),
            .NUM_WMASKS  (4),
            .READ_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk           (clk),
            .rstb          (rstb),
            .csb0          (csb0),
            .web0          (web0),
            .wmask0        (wmask0),
            .addr0         (addr0),
            .din0          (din0),
            .dout0         (d0_w[g]),
            .dout0_valid   (v0_w[g]),
            .csb1          (csb1),
            .addr1         (addr1),
            .dout1         (d1_w[g]),
            .dout1_valid   (v1_w[g]),
            .conflict      (cf_w[g]),
            .conflict_count(cc_w[g])
        );
    end

    function automatic int rl_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called after inputs are set, before the edge that samples them.
    task automatic exp_read(int port, logic [31:0] data);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.data = data;
            e.due  = cyc + rl_of(k);
            if (port == 0) q0[k].push_back(e);
            else           q1[k].push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'b0000;
        csb1   = 1'b1;
    endtask

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < 3; k++) n += q0[k].size() + q1[k].size();
        return n;
    endfunction

    task automatic drain();
        for (int t = 0; t < 12 && pending() != 0; t++) tick();
        chk("drain_pending", pending(), 0);
    endtask

    task automatic flush_from(int e);
        for (int k = 0; k < 3; k++) begin
            for (int j = q0[k].size() - 1; j >= 0; j--) if (q0[k][j].due >= e) q0[k].delete(j);
            for (int j = q1[k].size() - 1; j >= 0; j--) if (q1[k][j].due >= e) q1[k].delete(j);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_dout0"}, d0_w[0], 32'h0);
        chk({tag, "_dout1"}, d1_w[0], 32'h0);
        chk({tag, "_v0"}, {31'd0, v0_w[0]}, 32'h0);
        chk({tag, "_v1"}, {31'd0, v1_w[0]}, 32'h0);
        chk({tag, "_conflict"}, {31'd0, cf_w[0]}, 32'h0);
        chk({tag, "_count"}, {16'd0, cc_w[0]}, 32'h0);
    endtask

    // Scoreboard: every valid pulse must match the head entry in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (v0_w[k] === 1'b1) begin
                chk($sformatf("p0_expected_k%0d", k), q0[k].size() != 0, 1);
                if (q0[k].size() != 0) begin
                    e = q0[k].pop_front();
                    chk($sformatf("p0_data_k%0d", k), d0_w[k], e.data);
                    chk($sformatf("p0_cycle_k%0d", k), cyc, e.due);
                end
            end
            if (v1_w[k] === 1'b1) begin
                chk($sformatf("p1_expected_k%0d", k), q1[k].size() != 0, 1);
                if (q1[k].size() != 0) begin
                    e = q1[k].pop_front();
                    chk($sformatf("p1_data_k%0d", k), d1_w[k], e.data);
                    chk($sformatf("p1_cycle_k%0d", k), cyc, e.due);
                end
            end
        end
    end

    initial begin
        rstb   = 1'b0;
        addr0  = 8'h00;
        addr1  = 8'h00;
        din0   = 32'h0;
        idle();
        tick();
        tick();
        chk_reset_outputs("init_reset");
        rstb = 1'b1;
        tick();

        // basic write then port 1 read
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h10; din0 = 32'hDEADBEEF;
        tick();
        idle();
        csb1 = 1'b0; addr1 = 8'h10;
        exp_read(1, 32'hDEADBEEF);
        tick();
        idle();
        drain();

        // masked write then port 0 read
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0101; addr0 = 8'h10; din0 = 32'h11223344;
        tick();
        idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
        exp_read(0, 32'hDE22BE44);
        tick();
        idle();
        drain();

        // collision with read-before-write
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h20; din0 = 32'h55555555;
        tick();
        idle();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h20; din0 = 32'hAAAAAAAA;
        csb1 = 1'b0; addr1 = 8'h20;
        exp_read(1, 32'h55555555);
        tick();
        idle();
        chk("collide_conflict", {31'd0, cf_w[0]}, 32'd1);
        chk("collide_count", {16'd0, cc_w[0]}, 32'd1);
        tick();
        chk("collide_conflict_drop", {31'd0, cf_w[0]}, 32'd0);

        // zero-mask write on same address: no collision, no change
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0000; addr0 = 8'h20; din0 = 32'h12345678;
        csb1 = 1'b0; addr1 = 8'h20;
        exp_read(1, 32'hAAAAAAAA);
        tick();
        idle();
        chk("nomask_conflict", {31'd0, cf_w[0]}, 32'd0);
        chk("nomask_count", {16'd0, cc_w[0]}, 32'd1);

        // both ports read the same word on one edge
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20;
        csb1 = 1'b0; addr1 = 8'h20;
        exp_read(0, 32'hAAAAAAAA);
        exp_read(1, 32'hAAAAAAAA);
        tick();
        idle();
        drain();

        // streaming reads, back to back on port 1
        for (int i = 0; i < 8; i++) begin
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111;
            addr0 = 8'(i); din0 = 32'hC0DE0000 + 32'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            csb1 = 1'b0; addr1 = 8'(i);
            exp_read(1, 32'hC0DE0000 + 32'(i));
            tick();
        end
        idle();
        drain();

        // reset while a read is in flight; a write on a reset edge is ignored
        csb1 = 1'b0; addr1 = 8'h10;
        exp_read(1, 32'hDE22BE44);
        tick();
        idle();
        rstb = 1'b0;
        flush_from(cyc + 1);
        tick();
        chk_reset_outputs("midread_reset");
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h10; din0 = 32'h00000000;
        tick();
        idle();
        rstb = 1'b1;
        tick();
        tick();
        tick();
        chk("post_reset_v1", {31'd0, v1_w[0]}, 32'd0);
        chk("post_reset_dout1", d1_w[0], 32'h0);
        csb1 = 1'b0; addr1 = 8'h10;
        exp_read(1, 32'hDE22BE44);
        tick();
        idle();
        drain();

        // counter saturation
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h30; din0 = 32'h0F0F0F0F;
        tick();
        csb1 = 1'b0; addr1 = 8'h30;
        for (int i = 0; i < 65537; i++) begin
            exp_read(1, 32'h0F0F0F0F);
            tick();
            if (i == 65533) chk("count_fffe", {16'd0, cc_w[0]}, 32'h0000FFFE);
            if (i == 65534) chk("count_ffff", {16'd0, cc_w[0]}, 32'h0000FFFF);
        end
        idle();
        chk("sat_conflict", {31'd0, cf_w[0]}, 32'd1);
        chk("sat_count", {16'd0, cc_w[0]}, 32'h0000FFFF);
        tick();
        chk("sat_count_hold", {16'd0, cc_w[0]}, 32'h0000FFFF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
